// File: rtl/cache_ctrl_nway.sv
// cache_ctrl_nway: N-way set-associative cache controller for the 16-bit memory system.
//
// Accepts one read or write request in IDLE and compares all ways in parallel. A hit
// completes in two cycles. On a miss it picks a victim (first invalid way, otherwise the
// per-set round-robin pointer), writes the victim back when it is valid and dirty,
// streams a line fill from pipelined memory, and then performs the original access.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   Addr, DataIn, Rd, Wr        processor request (sampled in IDLE only)
//   hit_way/valid_way/dirty_way per-way compare results for the presented index/tag
//   tag_way, data_way           per-way stored tag and read data (way w in slice w)
//   DataOut_mem                 memory read data, MEM_RD_LAT cycles after rd_mem
//   enable_way, index_cache, offset_cache, tag_cache, cmp_ct, wr_cache, valid_in_ct,
//   DataIn_ct                   way-array control and write data
//   Addr_mem, DataIn_mem, wr_mem, rd_mem   memory port
//   Done, CacheHit, Stall_sys   completion pulse, hit flag, busy
//   err                         sticky protocol/consistency error
module cache_ctrl_nway #(
    parameter int unsigned WAYS       = 4,
    parameter int unsigned WORDS      = 4,
    parameter int unsigned INDEX_W    = 8,
    parameter int unsigned MEM_RD_LAT = 2,
    localparam int unsigned OFF_W     = $clog2(WORDS) + 1,
    localparam int unsigned TAG_W     = 16 - INDEX_W - OFF_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             Addr,
    input  logic [15:0]             DataIn,
    input  logic                    Rd,
    input  logic                    Wr,
    input  logic [WAYS-1:0]         hit_way,
    input  logic [WAYS-1:0]         valid_way,
    input  logic [WAYS-1:0]         dirty_way,
    input  logic [WAYS*TAG_W-1:0]   tag_way,
    input  logic [WAYS*16-1:0]      data_way,
    input  logic [15:0]             DataOut_mem,
    output logic [WAYS-1:0]         enable_way,
    output logic [INDEX_W-1:0]      index_cache,
    output logic [OFF_W-1:0]        offset_cache,
    output logic [TAG_W-1:0]        tag_cache,
    output logic                    cmp_ct,
    output logic                    wr_cache,
    output logic                    valid_in_ct,
    output logic [15:0]             DataIn_ct,
    output logic [15:0]             Addr_mem,
    output logic [15:0]             DataIn_mem,
    output logic                    wr_mem,
    output logic                    rd_mem,
    output logic                    Done,
    output logic                    CacheHit,
    output logic                    Stall_sys,
    output logic                    err
);

    localparam int unsigned WAY_W = $clog2(WAYS);
    localparam int unsigned WRD_W = $clog2(WORDS);
    localparam int unsigned SETS  = 2 ** INDEX_W;
    localparam int unsigned CNT_W = $clog2(WORDS + MEM_RD_LAT + 1);

    localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WORDS + MEM_RD_LAT - 1);
    localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(MEM_RD_LAT);

    typedef enum logic [2:0] {StIdle, StCmp, StHit, StWb, StFill, StFinal} state_e;

    state_e                 r_state;
    logic [TAG_W-1:0]       r_tag;
    logic [INDEX_W-1:0]     r_index;
    logic [WRD_W-1:0]       r_word;
    logic [15:0]            r_data;
    logic                   r_wr;
    logic [WAY_W-1:0]       r_victim;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_err;
    // Round-robin pointer per set, packed so the whole table clears in one assignment.
    logic [SETS*WAY_W-1:0]  r_rr;

    logic                   w_multi_hit;
    logic                   w_free_found;
    logic [WAY_W-1:0]       w_free_idx;
    logic [WAY_W-1:0]       w_rr_cur;
    logic [WAY_W-1:0]       w_victim_sel;
    logic                   w_victim_dirty;
    logic [TAG_W-1:0]       w_vic_tag;
    logic [15:0]            w_vic_data;
    logic [WAYS-1:0]        w_vic_onehot;
    logic [WRD_W-1:0]       w_cnt_word;
    logic [WRD_W-1:0]       w_fill_word;
    logic                   w_unused_addr0;

    // Byte address bit 0 carries no information for 16-bit words.
    assign w_unused_addr0 = Addr[0];

    // Any two bits set: clearing the lowest set bit leaves something behind.
    assign w_multi_hit = |(hit_way & (hit_way - WAYS'(1)));

    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_way[w]) begin
                w_free_found = 1'b1;
                w_free_idx   = WAY_W'(w);
            end
        end
    end

    assign w_rr_cur       = r_rr[int'(r_index) * WAY_W +: WAY_W];
    assign w_victim_sel   = w_free_found ? w_free_idx : w_rr_cur;
    assign w_victim_dirty = valid_way[w_victim_sel] & dirty_way[w_victim_sel];
    assign w_vic_tag      = tag_way[int'(r_victim) * TAG_W +: TAG_W];
    assign w_vic_data     = data_way[int'(r_victim) * 16 +: 16];
    assign w_vic_onehot   = WAYS'(1) << r_victim;
    assign w_cnt_word     = r_cnt[WRD_W-1:0];
    assign w_fill_word    = WRD_W'(r_cnt - LAT_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_tag    <= '0;
            r_index  <= '0;
            r_word   <= '0;
            r_data   <= '0;
            r_wr     <= 1'b0;
            r_victim <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rr     <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (Rd || Wr) begin
                        r_tag   <= Addr[15 -: TAG_W];
                        r_index <= Addr[OFF_W +: INDEX_W];
                        r_word  <= Addr[1 +: WRD_W];
                        r_data  <= DataIn;
                        r_wr    <= ~Rd;   // read wins when both strobes are high
                        if (Rd && Wr) begin
                            r_err <= 1'b1;
                        end
                        r_state <= StCmp;
                    end
                end
                StCmp: begin
                    if (|hit_way) begin
                        if (w_multi_hit) begin
                            r_err <= 1'b1;
                        end
                        r_state <= StHit;
                    end else begin
                        r_victim <= w_victim_sel;
                        r_cnt    <= '0;
                        r_state  <= w_victim_dirty ? StWb : StFill;
                    end
                end
                StHit: begin
                    r_state <= StIdle;
                end
                StWb: begin
                    if (r_cnt == WB_LAST) begin
                        r_cnt   <= '0;
                        r_state <= StFill;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StFill: begin
                    if (r_cnt == FILL_LAST) begin
                        r_cnt   <= '0;
                        r_state <= StFinal;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                StFinal: begin
                    r_rr[int'(r_index) * WAY_W +: WAY_W] <= r_victim + WAY_W'(1);
                    r_state                              <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Outputs decode the registered state, so an asynchronous reset drops every strobe
    // in the same cycle.
    always_comb begin
        enable_way   = '0;
        index_cache  = r_index;
        offset_cache = {r_word, 1'b0};
        tag_cache    = r_tag;
        cmp_ct       = 1'b0;
        wr_cache     = 1'b0;
        valid_in_ct  = 1'b0;
        DataIn_ct    = r_data;
        Addr_mem     = {r_tag, r_index, r_word, 1'b0};
        DataIn_mem   = w_vic_data;
        wr_mem       = 1'b0;
        rd_mem       = 1'b0;
        Done         = 1'b0;
        CacheHit     = 1'b0;
        Stall_sys    = (r_state != StIdle);
        err          = r_err;
        unique case (r_state)
            StIdle: begin
            end
            StCmp: begin
                enable_way = '1;
                cmp_ct     = 1'b1;
                wr_cache   = r_wr;
            end
            StHit: begin
                Done     = 1'b1;
                CacheHit = 1'b1;
            end
            StWb: begin
                enable_way   = w_vic_onehot;
                offset_cache = {w_cnt_word, 1'b0};
                wr_mem       = 1'b1;
                Addr_mem     = {w_vic_tag, r_index, w_cnt_word, 1'b0};
                DataIn_mem   = w_vic_data;
            end
            StFill: begin
                // Requests go out in the first WORDS cycles; data returns MEM_RD_LAT later,
                // so the two windows overlap.
                if (r_cnt < WORDS_C) begin
                    rd_mem   = 1'b1;
                    Addr_mem = {r_tag, r_index, w_cnt_word, 1'b0};
                end
                if (r_cnt >= LAT_C) begin
                    enable_way   = w_vic_onehot;
                    wr_cache     = 1'b1;
                    valid_in_ct  = 1'b1;
                    offset_cache = {w_fill_word, 1'b0};
                    DataIn_ct    = DataOut_mem;
                end
            end
            StFinal: begin
                enable_way = w_vic_onehot;
                cmp_ct     = 1'b1;
                wr_cache   = r_wr;
                Done       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
